// File: rtl/clock_set_ctrl.sv
// 24-hour BCD time-of-day counter with a RUN / SET_HR / SET_MIN set FSM.
// Buttons are synchronised and edge-detected; a 1 Hz tick comes from an internal divider.
module clock_set_ctrl #(
   parameter int unsigned SEC_TICK_DIV = 100_000_000
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       mode_pb,
   input  logic       inc_pb,
   output logic [1:0] hour_tens,
   output logic [3:0] hour_ones,
   output logic [2:0] min_tens,
   output logic [3:0] min_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [1:0] mode,
   output logic       blink,
   output logic       sec_pulse
);

   localparam int unsigned DIV_W = $clog2(SEC_TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SEC_TICK_DIV - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [DIV_W-1:0] div, div_nx;
   logic             mode_s1, mode_s2, mode_p;
   logic             inc_s1, inc_s2, inc_p;
   logic             mode_edge, inc_edge, tick;
   logic [1:0]       hour_tens_nx;
   logic [3:0]       hour_ones_nx, min_ones_nx, sec_ones_nx;
   logic [2:0]       min_tens_nx, sec_tens_nx;
   logic             blink_nx;

   // 23 -> 00 wrap, otherwise BCD +1
   function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] o);
      if (t == 2'd2 && o == 4'd3) return 6'd0;
      else if (o == 4'd9)         return {t + 2'd1, 4'd0};
      else                        return {t, o + 4'd1};
   endfunction

   // 59 -> 00 wrap, no carry out
   function automatic logic [6:0] min_inc(input logic [2:0] t, input logic [3:0] o);
      if (o != 4'd9)      return {t, o + 4'd1};
      else if (t == 3'd5) return 7'd0;
      else                return {t + 3'd1, 4'd0};
   endfunction

   // two-flop synchronisers plus history flop per button
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1 <= 1'b0; mode_s2 <= 1'b0; mode_p <= 1'b0;
         inc_s1  <= 1'b0; inc_s2  <= 1'b0; inc_p  <= 1'b0;
      end else begin
         mode_s1 <= mode_pb; mode_s2 <= mode_s1; mode_p <= mode_s2;
         inc_s1  <= inc_pb;  inc_s2  <= inc_s1;  inc_p  <= inc_s2;
      end
   end

   assign mode_edge = mode_s2 & ~mode_p;
   assign inc_edge  = inc_s2 & ~inc_p;
   assign tick      = (div == DIV_MAX);
   assign mode      = state;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         div       <= '0;
         hour_tens <= '0;
         hour_ones <= '0;
         min_tens  <= '0;
         min_ones  <= '0;
         sec_tens  <= '0;
         sec_ones  <= '0;
         blink     <= 1'b0;
         sec_pulse <= 1'b0;
      end else begin
         state     <= state_nx;
         div       <= div_nx;
         hour_tens <= hour_tens_nx;
         hour_ones <= hour_ones_nx;
         min_tens  <= min_tens_nx;
         min_ones  <= min_ones_nx;
         sec_tens  <= sec_tens_nx;
         sec_ones  <= sec_ones_nx;
         blink     <= blink_nx;
         sec_pulse <= tick;
      end
   end

   // next-state and next-time; a mode edge always pre-empts inc and tick effects
   always_comb begin
      state_nx     = state;
      div_nx       = tick ? '0 : div + DIV_W'(1);
      hour_tens_nx = hour_tens;
      hour_ones_nx = hour_ones;
      min_tens_nx  = min_tens;
      min_ones_nx  = min_ones;
      sec_tens_nx  = sec_tens;
      sec_ones_nx  = sec_ones;
      blink_nx     = 1'b0;
      case (state)
         RUN: begin
            if (mode_edge) begin
               state_nx    = SET_HR;
               sec_tens_nx = '0;
               sec_ones_nx = '0;
            end else if (tick) begin
               if (sec_ones != 4'd9) begin
                  sec_ones_nx = sec_ones + 4'd1;
               end else begin
                  sec_ones_nx = '0;
                  if (sec_tens != 3'd5) begin
                     sec_tens_nx = sec_tens + 3'd1;
                  end else begin
                     sec_tens_nx = '0;
                     {min_tens_nx, min_ones_nx} = min_inc(min_tens, min_ones);
                     if (min_tens == 3'd5 && min_ones == 4'd9)
                        {hour_tens_nx, hour_ones_nx} = hour_inc(hour_tens, hour_ones);
                  end
               end
            end
         end
         SET_HR: begin
            sec_tens_nx = '0;
            sec_ones_nx = '0;
            if (mode_edge) begin
               state_nx = SET_MIN;
            end else begin
               blink_nx = tick ? ~blink : blink;
               if (inc_edge) {hour_tens_nx, hour_ones_nx} = hour_inc(hour_tens, hour_ones);
            end
         end
         SET_MIN: begin
            sec_tens_nx = '0;
            sec_ones_nx = '0;
            if (mode_edge) begin
               state_nx = RUN;
               div_nx   = '0;
            end else begin
               blink_nx = tick ? ~blink : blink;
               if (inc_edge) {min_tens_nx, min_ones_nx} = min_inc(min_tens, min_ones);
            end
         end
         default: begin
            if (mode_edge) state_nx = RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a 4-cycle second: reset, carry chain,
// set-mode increments, held buttons, simultaneous edges, blink and mid-set reset.
module tb_clock_set_ctrl;

   localparam int unsigned DIV = 4;

   logic       clk_in;
   logic       rst_n;
   logic       mode_pb;
   logic       inc_pb;
   logic [1:0] hour_tens;
   logic [3:0] hour_ones;
   logic [2:0] min_tens;
   logic [3:0] min_ones;
   logic [2:0] sec_tens;
   logic [3:0] sec_ones;
   logic [1:0] mode;
   logic       blink;
   logic       sec_pulse;

   int   vectors    = 0;
   int   miscompares = 0;
   int   cyc        = 0;
   int   base       = 0;
   int   last_upd   = 0;
   logic exp_blink;

   clock_set_ctrl #(.SEC_TICK_DIV(DIV)) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .mode_pb   (mode_pb),
      .inc_pb    (inc_pb),
      .hour_tens (hour_tens),
      .hour_ones (hour_ones),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .mode      (mode),
      .blink     (blink),
      .sec_pulse (sec_pulse)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // edges since the last divider clear at which a second elapses
   function automatic bit is_tick(input int e);
      return (e > base) && (((e - base) % DIV) == 0);
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_time(input string tag, input int ht, input int ho, input int mt,
                           input int mo, input int st, input int so);
      chk({tag, ".ht"}, 8'(hour_tens), 8'(ht));
      chk({tag, ".ho"}, 8'(hour_ones), 8'(ho));
      chk({tag, ".mt"}, 8'(min_tens),  8'(mt));
      chk({tag, ".mo"}, 8'(min_ones),  8'(mo));
      chk({tag, ".st"}, 8'(sec_tens),  8'(st));
      chk({tag, ".so"}, 8'(sec_ones),  8'(so));
   endtask

   // two-cycle press; returns three edges after the edge that applies it
   task automatic press(input logic m, input logic i);
      if (m) mode_pb = 1'b1;
      if (i) inc_pb  = 1'b1;
      @(posedge clk_in); #1;
      last_upd = cyc + 2;
      @(posedge clk_in); #1;
      if (m) mode_pb = 1'b0;
      if (i) inc_pb  = 1'b0;
      repeat (4) @(posedge clk_in);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; mode_pb = 1'b0; inc_pb = 1'b0; exp_blink = 1'b0;
      #2;
      chk_time("rst", 0, 0, 0, 0, 0, 0);
      chk("rst.mode",  8'(mode),      8'd0);
      chk("rst.blink", 8'(blink),     8'd0);
      chk("rst.pulse", 8'(sec_pulse), 8'd0);

      // first second after reset release
      @(negedge clk_in); rst_n = 1'b1;
      repeat (3) @(posedge clk_in); #1;
      chk("pre.pulse", 8'(sec_pulse), 8'd0);
      chk("pre.so",    8'(sec_ones),  8'd0);
      @(posedge clk_in); #1;
      chk("wrap.pulse", 8'(sec_pulse), 8'd1);
      chk_time("wrap", 0, 0, 0, 0, 0, 1);
      @(posedge clk_in); #1;
      chk("post.pulse", 8'(sec_pulse), 8'd0);

      // preload 23:59 through the set path, exercising both wraps
      press(1'b1, 1'b0);
      chk("sethr.mode", 8'(mode), 8'd1);
      chk_time("sethr", 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 23; n++) press(1'b0, 1'b1);
      chk_time("hr23", 2, 3, 0, 0, 0, 0);
      press(1'b0, 1'b1);
      chk_time("hrwrap", 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 23; n++) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      chk("setmin.mode", 8'(mode), 8'd2);
      for (int n = 0; n < 59; n++) press(1'b0, 1'b1);
      chk_time("min59", 2, 3, 5, 9, 0, 0);
      press(1'b0, 1'b1);
      chk_time("minwrap", 2, 3, 0, 0, 0, 0);
      for (int n = 0; n < 59; n++) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      base = last_upd;
      chk("run.mode",  8'(mode),      8'd0);
      chk("run.pulse", 8'(sec_pulse), 8'd0);
      chk_time("run0", 2, 3, 5, 9, 0, 0);
      @(posedge clk_in); #1;
      chk("run1.pulse", 8'(sec_pulse), 8'd1);
      chk_time("run1", 2, 3, 5, 9, 0, 1);
      repeat (58 * DIV) @(posedge clk_in);
      #1;
      chk_time("t235959", 2, 3, 5, 9, 5, 9);
      repeat (DIV - 1) @(posedge clk_in);
      #1;
      chk_time("hold59", 2, 3, 5, 9, 5, 9);
      @(posedge clk_in); #1;
      chk_time("midnight", 0, 0, 0, 0, 0, 0);

      // held inc in SET_HR: exactly one increment at k+2
      press(1'b1, 1'b0);
      chk("c.mode", 8'(mode), 8'd1);
      inc_pb = 1'b1;
      @(posedge clk_in); #1;
      chk("c.k", 8'(hour_ones), 8'd0);
      @(posedge clk_in); #1;
      chk("c.k1", 8'(hour_ones), 8'd0);
      @(posedge clk_in); #1;
      chk("c.k2", 8'(hour_ones), 8'd1);
      repeat (47) @(posedge clk_in);
      #1;
      chk("c.held", 8'(hour_ones), 8'd1);
      inc_pb = 1'b0;
      repeat (4) @(posedge clk_in);
      #1;
      chk_time("c.rel", 0, 1, 0, 0, 0, 0);

      // simultaneous mode+inc in RUN, then blink behaviour in SET_HR
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      base = last_upd;
      chk("d.mode", 8'(mode), 8'd0);
      chk_time("d.run", 0, 1, 0, 0, 0, 0);
      press(1'b1, 1'b1);
      chk("d.both.mode", 8'(mode), 8'd1);
      chk_time("d.both", 0, 1, 0, 0, 0, 0);
      exp_blink = 1'b0;
      for (int e = last_upd + 1; e <= cyc; e++)
         if (is_tick(e)) exp_blink = ~exp_blink;
      chk("d.blink0", 8'(blink), 8'(exp_blink));
      for (int n = 0; n < 12; n++) begin
         @(posedge clk_in); #1;
         if (is_tick(cyc)) exp_blink = ~exp_blink;
         chk("d.blink", 8'(blink),     8'(exp_blink));
         chk("d.pulse", 8'(sec_pulse), 8'(is_tick(cyc)));
      end
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      base = last_upd;
      chk("d.back.mode",  8'(mode),  8'd0);
      chk("d.back.blink", 8'(blink), 8'd0);

      // reset mid-SET_MIN with inc held
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      for (int n = 0; n < 3; n++) press(1'b0, 1'b1);
      chk_time("e.min3", 0, 1, 0, 3, 0, 0);
      inc_pb = 1'b1;
      repeat (5) @(posedge clk_in);
      #1;
      chk("e.min4", 8'(min_ones), 8'd4);
      rst_n = 1'b0;
      #1;
      chk_time("e.rst", 0, 0, 0, 0, 0, 0);
      chk("e.rst.mode",  8'(mode),  8'd0);
      chk("e.rst.blink", 8'(blink), 8'd0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in); rst_n = 1'b1;
      repeat (6) @(posedge clk_in);
      #1;
      press(1'b1, 1'b0);
      chk("e.sethr.mode", 8'(mode), 8'd1);
      chk_time("e.sethr", 0, 0, 0, 0, 0, 0);
      repeat (6) @(posedge clk_in);
      #1;
      chk("e.noinc", 8'(hour_ones), 8'd0);
      inc_pb = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      press(1'b0, 1'b1);
      chk_time("e.inc", 0, 1, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
